// File: rtl/fixed_pkg.sv
// Shared signed fixed-point types and the multiply used by the integrator datapath.
// fx_mul is sign-magnitude with truncation toward zero, matching fp_mul bit for bit.
package fixed_pkg;
  localparam int N_DEF    = 32;
  localparam int FRAC     = N_DEF / 2;
  localparam int AXES_DEF = 3;

  typedef logic signed [N_DEF-1:0] fixed_t;
  typedef fixed_t [AXES_DEF-1:0]   vec_t;

  function automatic fixed_t fx_mul(input fixed_t x, input fixed_t y);
    logic               s;
    logic [N_DEF-1:0]   mx;
    logic [N_DEF-1:0]   my;
    logic [2*N_DEF-1:0] prod;
    logic [N_DEF-1:0]   r;
    s    = x[N_DEF-1] ^ y[N_DEF-1];
    mx   = x[N_DEF-1] ? (~x + 1'b1) : x;
    my   = y[N_DEF-1] ? (~y + 1'b1) : y;
    prod = {{N_DEF{1'b0}}, mx} * {{N_DEF{1'b0}}, my};
    // Keep product bits [3N/2-1:N/2]; the most-negative magnitude wraps to itself.
    r    = N_DEF'(prod >> FRAC);
    return s ? fixed_t'(~r + 1'b1) : fixed_t'(r);
  endfunction
endpackage

// File: rtl/euler_axis.sv
// One axis of the integrator: S1 holds {p, v+a*dt, dt}, S2 holds {p+v'*dt, v'}.
// Pure datapath; load enables come from the shared control in euler_step.
module euler_axis
  import fixed_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   s1_en,
  input  logic   s2_en,
  input  fixed_t in_pos,
  input  fixed_t in_vel,
  input  fixed_t in_acc,
  input  fixed_t in_dt,
  output fixed_t out_pos,
  output fixed_t out_vel
);
  fixed_t s1_pos, s1_vel, s1_dt;
  fixed_t s2_pos, s2_vel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_pos <= '0;
      s1_vel <= '0;
      s1_dt  <= '0;
      s2_pos <= '0;
      s2_vel <= '0;
    end else begin
      if (s1_en) begin
        s1_pos <= in_pos;
        s1_vel <= in_vel + fx_mul(in_acc, in_dt);
        s1_dt  <= in_dt;
      end
      // Semi-implicit: position advances with the already-updated velocity.
      if (s2_en) begin
        s2_pos <= s1_pos + fx_mul(s1_vel, s1_dt);
        s2_vel <= s1_vel;
      end
    end
  end

  assign out_pos = s2_pos;
  assign out_vel = s2_vel;
endmodule

// File: rtl/euler_step.sv
// Two-stage semi-implicit Euler step, 2-cycle latency, 1 transaction/cycle.
// Valid/ready on both sides; in_ready depends on out_ready but never on in_valid.
module euler_step
  import fixed_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int AXES = AXES_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N*AXES-1:0] in_pos,
  input  logic [N*AXES-1:0] in_vel,
  input  logic [N*AXES-1:0] in_acc,
  input  logic [N-1:0]      in_dt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N*AXES-1:0] out_pos,
  output logic [N*AXES-1:0] out_vel,
  output logic [31:0]       step_cnt
);
  logic        s1_valid, s2_valid;
  logic        s1_load, s2_load;
  logic        s1_en, s2_en;
  logic [31:0] cnt_q;

  assign s2_load  = !s2_valid || out_ready;
  assign s1_load  = !s1_valid || s2_load;
  assign in_ready = s1_load;
  assign s1_en    = s1_load && in_valid;
  assign s2_en    = s2_load && s1_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (s1_load) s1_valid <= in_valid;
      if (s2_load) s2_valid <= s1_valid;
      if (s2_valid && out_ready) cnt_q <= cnt_q + 32'd1;
    end
  end

  assign out_valid = s2_valid;
  assign step_cnt  = cnt_q;

  for (genvar i = 0; i < AXES; i++) begin : g_axis
    euler_axis u_axis (
      .clk     (clk),
      .rst_n   (rst_n),
      .s1_en   (s1_en),
      .s2_en   (s2_en),
      .in_pos  (in_pos[i*N +: N]),
      .in_vel  (in_vel[i*N +: N]),
      .in_acc  (in_acc[i*N +: N]),
      .in_dt   (in_dt),
      .out_pos (out_pos[i*N +: N]),
      .out_vel (out_vel[i*N +: N])
    );
  end
endmodule

// File: tb/tb_euler_step.sv
// Scoreboard bench for euler_step: directed vectors push expectations, a monitor pops them.
module tb_euler_step;
  logic        clk, rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [95:0] in_pos, in_vel, in_acc, out_pos, out_vel;
  logic [31:0] in_dt, step_cnt;

  int errors = 0;
  int checks = 0;
  int accepted = 0;
  logic [95:0] exp_pos_q[$];
  logic [95:0] exp_vel_q[$];

  euler_step dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pos(in_pos), .in_vel(in_vel), .in_acc(in_acc), .in_dt(in_dt),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pos(out_pos), .out_vel(out_vel), .step_cnt(step_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [95:0] v3(input logic [31:0] a0, input logic [31:0] a1,
                                     input logic [31:0] a2);
    return {a2, a1, a0};
  endfunction

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Monitor: pops on each output transfer, and checks that a stalled output holds.
  logic        held = 1'b0;
  logic [95:0] hold_pos, hold_vel;
  always @(negedge clk) begin
    if (!rst_n) begin
      held = 1'b0;
    end else begin
      if (held) begin
        checks++;
        if (out_valid !== 1'b1 || out_pos !== hold_pos || out_vel !== hold_vel) begin
          errors++;
          $display("FAIL hold: got v=%b p=%h vel=%h expected v=1 p=%h vel=%h",
                   out_valid, out_pos, out_vel, hold_pos, hold_vel);
        end
      end
      if (out_valid && out_ready) begin
        held = 1'b0;
        checks++;
        if (exp_pos_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: got p=%h vel=%h expected none", out_pos, out_vel);
        end else begin
          logic [95:0] ep, ev;
          ep = exp_pos_q.pop_front();
          ev = exp_vel_q.pop_front();
          if (out_pos !== ep) begin
            errors++;
            $display("FAIL out_pos: got %h expected %h", out_pos, ep);
          end
          checks++;
          if (out_vel !== ev) begin
            errors++;
            $display("FAIL out_vel: got %h expected %h", out_vel, ev);
          end
        end
      end else if (out_valid) begin
        held = 1'b1;
        hold_pos = out_pos;
        hold_vel = out_vel;
      end else begin
        held = 1'b0;
      end
    end
  end

  task automatic send(input logic [95:0] p, input logic [95:0] v, input logic [95:0] a,
                      input logic [31:0] dt, input logic [95:0] ep, input logic [95:0] ev,
                      output int stalls);
    stalls = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_pos = p; in_vel = v; in_acc = a; in_dt = dt;
    #1;
    while (!in_ready && stalls < 100) begin
      @(negedge clk);
      #1;
      stalls++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 within 100 cycles");
    end else begin
      exp_pos_q.push_back(ep);
      exp_vel_q.push_back(ev);
      accepted++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_pos_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_pos_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_pos_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic b2b_vec(input int i, output logic [95:0] p, output logic [95:0] ep);
    p  = v3(32'(i) << 16, 32'(i + 1) << 16, 32'(i + 2) << 16);
    ep = v3(32'(i + 1) << 16, 32'(i + 2) << 16, 32'(i + 3) << 16);
  endtask

  int st;
  logic [95:0] bp, bep;
  logic [95:0] ONE3;

  initial begin
    ONE3 = v3(32'h0001_0000, 32'h0001_0000, 32'h0001_0000);
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_pos = '0; in_vel = '0; in_acc = '0; in_dt = '0;
    #2;
    check32("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check32("rst_out_pos0", out_pos[31:0], 32'd0);
    check32("rst_out_vel0", out_vel[31:0], 32'd0);
    check32("rst_step_cnt", step_cnt, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check32("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Basic step, truncation to zero, and negative product on three axes.
    send(v3(32'h0001_0000, 32'h0, 32'h0), v3(32'h0002_0000, 32'h0, 32'h0),
         v3(32'hFFFF_0000, 32'hFFFF_FFFF, 32'hFFFD_0000), 32'h0000_8000,
         v3(32'h0001_C000, 32'h0, 32'hFFFF_4000), v3(32'h0001_8000, 32'h0, 32'hFFFE_8000), st);
    check32("lat_cycle1_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    check32("lat_cycle2_valid", {31'd0, out_valid}, 32'd1);
    drain();
    check32("step_cnt_basic", step_cnt, 32'd1);

    // Negative dt, and signed wrap with no saturation.
    send(v3(32'h0, 32'h0005_0000, 32'h0), v3(32'h0, 32'h0001_0000, 32'h0000_0003),
         v3(32'hFFFD_0000, 32'h0000_8000, 32'h0), 32'hFFFE_0000,
         v3(32'hFFF4_0000, 32'h0005_0000, 32'hFFFF_FFFA), v3(32'h0006_0000, 32'h0, 32'h3), st);
    send(v3(32'h0, 32'h0001_0000, 32'h0), v3(32'h7FFF_0000, 32'h0002_0000, 32'hFFFF_8000),
         v3(32'h0001_0000, 32'h0, 32'h0), 32'h0001_0000,
         v3(32'h8000_0000, 32'h0003_0000, 32'hFFFF_8000),
         v3(32'h8000_0000, 32'h0002_0000, 32'hFFFF_8000), st);
    drain();
    check32("step_cnt_signs", step_cnt, 32'd3);

    for (int i = 0; i < 8; i++) begin
      b2b_vec(i, bp, bep);
      send(bp, ONE3, '0, 32'h0001_0000, bep, ONE3, st);
      check32("b2b_stalls", 32'(st), 32'd0);
    end
    drain();
    check32("step_cnt_b2b", step_cnt, 32'd11);

    out_ready = 1'b0;
    accepted = 0;
    fork
      begin
        for (int i = 20; i < 23; i++) begin
          logic [95:0] fp, fep;
          int fst;
          b2b_vec(i, fp, fep);
          send(fp, ONE3, '0, 32'h0001_0000, fep, ONE3, fst);
        end
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        check32("bp_accepted", 32'(accepted), 32'd2);
        check32("bp_in_ready", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
      end
    join
    drain();
    check32("step_cnt_bp", step_cnt, 32'd14);

    @(negedge clk);
    force dut.cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.cnt_q;
    b2b_vec(40, bp, bep);
    send(bp, ONE3, '0, 32'h0001_0000, bep, ONE3, st);
    drain();
    check32("step_cnt_max", step_cnt, 32'hFFFF_FFFF);
    b2b_vec(41, bp, bep);
    send(bp, ONE3, '0, 32'h0001_0000, bep, ONE3, st);
    drain();
    check32("step_cnt_wrap", step_cnt, 32'd0);

    // Fill both stages, then reset asynchronously between clock edges.
    out_ready = 1'b0;
    b2b_vec(50, bp, bep);
    send(bp, ONE3, '0, 32'h0001_0000, bep, ONE3, st);
    b2b_vec(51, bp, bep);
    send(bp, ONE3, '0, 32'h0001_0000, bep, ONE3, st);
    #1;
    check32("full_before_reset", {31'd0, out_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check32("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check32("midrst_step_cnt", step_cnt, 32'd0);
    check32("midrst_out_pos0", out_pos[31:0], 32'd0);
    exp_pos_q.delete();
    exp_vel_q.delete();
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    out_ready = 1'b1;
    send(v3(32'h0001_0000, 32'h0, 32'h0), v3(32'h0002_0000, 32'h0, 32'h0),
         v3(32'hFFFF_0000, 32'hFFFF_FFFF, 32'hFFFD_0000), 32'h0000_8000,
         v3(32'h0001_C000, 32'h0, 32'hFFFF_4000), v3(32'h0001_8000, 32'h0, 32'hFFFE_8000), st);
    check32("post_rst_lat1", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    check32("post_rst_lat2", {31'd0, out_valid}, 32'd1);
    drain();
    check32("post_rst_step_cnt", step_cnt, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
